usr_shift_n: RTL and testbench



---
 rtl/usr_shift_n.sv | 104 ++++++++++
 tb/tb_usr_shift_n.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_n.sv
// rtl/usr_shift_n.sv - parametrised universal shift register with counted burst engine
module usr_shift_n #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             CP,
    input  logic             MR,
    input  logic [WIDTH-1:0] D,
    input  logic [2:0]       S,
    input  logic             DSR,
    input  logic             DSL,
    input  logic             EN,
    input  logic             START,
    input  logic [CW-1:0]    CNT,
    output logic [WIDTH-1:0] Q,
    output logic             SOR,
    output logic             SOL,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [2:0]         step_mode;
    logic [WIDTH-1:0]   q_step;

    // A burst steps with the mode latched at START; single steps use S live.
    always_comb begin
        step_mode = (state_q == RUN) ? mode_q : S;
        case (step_mode)
            3'b001:  q_step = {DSR, q_q[WIDTH-1:1]};
            3'b010:  q_step = {q_q[WIDTH-2:0], DSL};
            3'b011:  q_step = D;
            3'b100:  q_step = {q_q[0], q_q[WIDTH-1:1]};
            3'b101:  q_step = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            3'b110:  q_step = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            default: q_step = q_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (CNT == '0) begin
                        state_d = FIN;
                    end else begin
                        mode_d  = S;
                        cnt_d   = CNT;
                        state_d = RUN;
                    end
                end else if (EN) begin
                    q_d = q_step;
                end
            end
            RUN: begin
                q_d   = q_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 3'b000;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
        end
    end

    assign Q    = q_q;
    assign SOR  = q_q[0];
    assign SOL  = q_q[WIDTH-1];
    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_usr_shift_n.sv
// tb/tb_usr_shift_n.sv - randomized self-checking bench for usr_shift_n
module tb_usr_shift_n;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          CP;
    logic          MR;
    logic [W-1:0]  D;
    logic [2:0]    S;
    logic          DSR;
    logic          DSL;
    logic          EN;
    logic          START;
    logic [CW-1:0] CNT;
    logic [W-1:0]  Q;
    logic          SOR;
    logic          SOL;
    logic          BUSY;
    logic          DONE;

    int n_checks;
    int n_fail;
    logic [W-1:0] mq;

    usr_shift_n #(.WIDTH(W), .CW(CW)) dut (
        .CP(CP), .MR(MR), .D(D), .S(S), .DSR(DSR), .DSL(DSL), .EN(EN),
        .START(START), .CNT(CNT), .Q(Q), .SOR(SOR), .SOL(SOL),
        .BUSY(BUSY), .DONE(DONE)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Reference: one step of each mode expressed as plain shift arithmetic.
    function automatic logic [W-1:0] m_step(input logic [2:0] s, input logic [W-1:0] q,
                                            input logic [W-1:0] d, input logic dsr,
                                            input logic dsl);
        logic [W-1:0] r;
        case (s)
            3'd1:    r = (q >> 1) | (W'(dsr) << (W - 1));
            3'd2:    r = (q << 1) | W'(dsl);
            3'd3:    r = d;
            3'd4:    r = (q >> 1) | (W'(q[0]) << (W - 1));
            3'd5:    r = (q << 1) | W'(q[W-1]);
            3'd6:    r = W'($signed(q) >>> 1);
            default: r = q;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic idle_inputs();
        MR = 0; START = 0; EN = 0; S = 3'd0; CNT = '0;
    endtask

    task automatic load(input logic [W-1:0] v);
        S = 3'b011; D = v; EN = 1; START = 0;
        tick();
        EN = 0;
        mq = v;
        n_checks++;
        if (Q !== v) begin
            n_fail++; $display("FAIL load: Q=%h expected %h", Q, v);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        D = 8'hFF; DSR = 1; DSL = 1;
        MR = 1;
        tick();
        MR = 0;
        mq = '0;
        n_checks++;
        if ({Q, SOR, SOL, BUSY, DONE} !== {8'h00, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset: Q=%h SOR=%b SOL=%b BUSY=%b DONE=%b expected all zero",
                     Q, SOR, SOL, BUSY, DONE);
        end
        load(8'hA5);
        n_checks++;
        if (SOR !== 1'b1 || SOL !== 1'b1) begin
            n_fail++; $display("FAIL load_serial_out: SOR=%b SOL=%b expected 1 1", SOR, SOL);
        end
    endtask

    task automatic test_fixed_steps();
        logic [2:0]   modes [3] = '{3'b001, 3'b010, 3'b110};
        logic [W-1:0] exp_q [3] = '{8'h52, 8'hA5, 8'hD2};
        DSR = 0; DSL = 1; EN = 1;
        for (int i = 0; i < 3; i++) begin
            S = modes[i];
            tick();
            n_checks++;
            if (Q !== exp_q[i]) begin
                n_fail++; $display("FAIL fixed_step%0d: Q=%h expected %h", i, Q, exp_q[i]);
            end
        end
        EN = 0;
        mq = 8'hD2;
    endtask

    task automatic test_random_steps();
        for (int i = 0; i < 60; i++) begin
            S   = 3'($urandom_range(0, 7));
            D   = W'($urandom);
            DSR = 1'($urandom);
            DSL = 1'($urandom);
            EN  = 1'($urandom_range(0, 3) != 0);
            if (EN) mq = m_step(S, mq, D, DSR, DSL);
            tick();
            n_checks++;
            if (Q !== mq || SOR !== mq[0] || SOL !== mq[W-1] || BUSY !== 0 || DONE !== 0) begin
                n_fail++;
                $display("FAIL random_step%0d: Q=%h SOR=%b SOL=%b BUSY=%b DONE=%b expected Q=%h idle",
                         i, Q, SOR, SOL, BUSY, DONE, mq);
            end
        end
        EN = 0;
    endtask

    // Generic burst: dsr_sel 0/1 forces DSR, 2 randomizes it live every step.
    task automatic run_burst(input logic [2:0] mode, input int n, input int dsr_sel);
        int busy_cycles;
        S = mode; CNT = CW'(n); START = 1; EN = 1'($urandom);
        tick();
        START = 0;
        busy_cycles = (BUSY === 1'b1) ? 1 : 0;
        n_checks++;
        if (BUSY !== (n != 0) || DONE !== (n == 0) || Q !== mq) begin
            n_fail++;
            $display("FAIL burst_start n=%0d: BUSY=%b DONE=%b Q=%h expected BUSY=%b DONE=%b Q=%h",
                     n, BUSY, DONE, Q, n != 0, n == 0, mq);
        end
        for (int k = 1; k <= n; k++) begin
            S     = 3'($urandom_range(0, 7));
            EN    = 1'($urandom);
            START = 1'($urandom);
            CNT   = CW'($urandom);
            D     = W'($urandom);
            DSR   = (dsr_sel == 2) ? 1'($urandom) : 1'(dsr_sel);
            DSL   = 1'($urandom);
            mq = m_step(mode, mq, D, DSR, DSL);
            tick();
            if (BUSY === 1'b1) busy_cycles++;
            n_checks++;
            if (Q !== mq || BUSY !== (k < n) || DONE !== (k == n)) begin
                n_fail++;
                $display("FAIL burst_step%0d/%0d mode=%0d: Q=%h BUSY=%b DONE=%b expected Q=%h BUSY=%b DONE=%b",
                         k, n, mode, Q, BUSY, DONE, mq, k < n, k == n);
            end
        end
        START = 1'($urandom); EN = 1; S = 3'b011; D = ~mq;
        tick();
        START = 0; EN = 0;
        n_checks++;
        if (DONE !== 0 || BUSY !== 0 || Q !== mq || busy_cycles != n) begin
            n_fail++;
            $display("FAIL burst_end n=%0d: DONE=%b BUSY=%b Q=%h busy_cycles=%0d expected 0 0 %h %0d",
                     n, DONE, BUSY, Q, busy_cycles, mq, n);
        end
    endtask

    task automatic test_rotate_burst();
        load(8'h81);
        run_burst(3'b101, 3, 2);
        n_checks++;
        if (Q !== 8'h0C) begin
            n_fail++; $display("FAIL rotate_burst_result: Q=%h expected 0c", Q);
        end
    endtask

    task automatic test_overlong_burst();
        load(8'hFF);
        run_burst(3'b001, 9, 0);
        n_checks++;
        if (Q !== 8'h00) begin
            n_fail++; $display("FAIL overlong_burst_result: Q=%h expected 00", Q);
        end
        load(8'h96);
        run_burst(3'b100, 11, 2);
        n_checks++;
        if (Q !== 8'hD2) begin
            n_fail++; $display("FAIL overlong_rotate_result: Q=%h expected d2", Q);
        end
    endtask

    task automatic test_cnt_zero_and_priority();
        load(8'h3C);
        EN = 1; S = 3'b011; D = 8'h00; START = 1; CNT = '0;
        tick();
        START = 0; EN = 0;
        n_checks++;
        if (DONE !== 1 || BUSY !== 0 || Q !== 8'h3C) begin
            n_fail++;
            $display("FAIL cnt_zero: DONE=%b BUSY=%b Q=%h expected 1 0 3c", DONE, BUSY, Q);
        end
        tick();
        n_checks++;
        if (DONE !== 0 || BUSY !== 0 || Q !== 8'h3C) begin
            n_fail++;
            $display("FAIL cnt_zero_after: DONE=%b BUSY=%b Q=%h expected 0 0 3c", DONE, BUSY, Q);
        end
    endtask

    task automatic test_random_bursts();
        for (int i = 0; i < 12; i++) begin
            load(W'($urandom));
            run_burst(3'($urandom_range(0, 7)), $urandom_range(0, 15), 2);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic saw_done;
        load(8'hF0);
        S = 3'b100; CNT = CW'(5); START = 1;
        tick();
        START = 0;
        tick();
        MR = 1;
        tick();
        MR = 0;
        n_checks++;
        if (Q !== 8'h00 || BUSY !== 0 || DONE !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_burst: Q=%h BUSY=%b DONE=%b expected 00 0 0", Q, BUSY, DONE);
        end
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (DONE === 1'b1 || BUSY === 1'b1) saw_done = 1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_burst_quiet: activity=%b expected 0", saw_done);
        end
        mq = 8'h00;
        load(8'h01);
        run_burst(3'b010, 1, 2);
        n_checks++;
        if (Q[7:1] !== 7'h01) begin
            n_fail++; $display("FAIL post_reset_burst: Q=%h expected 0000001x", Q);
        end
    endtask

    task automatic test_reset_in_fin();
        load(8'h55);
        S = 3'b001; CNT = CW'(1); START = 1; DSR = 1;
        tick();
        START = 0;
        tick();
        MR = 1;
        tick();
        MR = 0;
        n_checks++;
        if (DONE !== 0 || BUSY !== 0 || Q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_in_fin: DONE=%b BUSY=%b Q=%h expected 0 0 00", DONE, BUSY, Q);
        end
        mq = 8'h00;
        run_burst(3'b001, 2, 1);
        n_checks++;
        if (Q !== 8'hC0) begin
            n_fail++; $display("FAIL burst_after_fin_reset: Q=%h expected c0", Q);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mq       = '0;
        idle_inputs();
        D = '0; DSR = 0; DSL = 0;
        tick();
        test_reset();
        test_fixed_steps();
        test_random_steps();
        test_rotate_burst();
        test_overlong_burst();
        test_cnt_zero_and_priority();
        test_random_bursts();
        test_reset_mid_burst();
        test_reset_in_fin();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
